anemo_ram_arbiter: RTL and testbench

ANEMO_RAM_ARBITER -- requirements
Module: anemo_ram_arbiter

---
 rtl/anemo_arb_pkg.sv | 17 +
 rtl/anemo_rr_pick2.sv | 23 ++
 rtl/anemo_ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_anemo_ram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/anemo_arb_pkg.sv
// Shared types for the two-requester RAM arbiter: ownership states and
// the requester index used for round-robin history and read-data routing.
package anemo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  // Requester 1 counts as the previous winner out of reset, so requester 0
  // wins the very first conflict.
  localparam req_idx_t RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/anemo_rr_pick2.sv
// Two-way winner selection. Round-robin on conflict (the requester that did
// not win last time wins now), or fixed priority to requester 0 when 'fixed'
// is high. Grant is one-hot, or zero when nothing is requested.
module anemo_rr_pick2
  import anemo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  input  logic       fixed,
  output logic [1:0] grant
);

  // A single requester always wins; a conflict goes to the non-last requester.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (fixed || (last == 1'b1)) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/anemo_ram_arbiter.sv
// Arbitrates two Avalon-style masters onto one single-port synchronous RAM.
// At most one access is accepted per cycle and issued to the RAM the same
// cycle; a requester may lock the grant across several accesses. Read data
// comes back one cycle later and is routed by a registered {valid, owner} tag.
// Addresses at or above DEPTH are accepted but never reach the RAM: writes
// are dropped and reads return zero.
// Optional build macro: ANEMO_ARB_FIXED_PRIO_EN -- requester 0 always wins
// conflicts in IDLE instead of round-robin.
module anemo_ram_arbiter
  import anemo_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10240
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                m0_read,
  input  logic                m0_write,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic                m1_read,
  input  logic                m1_write,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                ram_clken
);

`ifdef ANEMO_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_t state, state_nxt;
  req_idx_t   last_grant;
  logic       tag_valid, tag_oor;
  req_idx_t   tag_owner;

  logic [1:0] pending, is_wr, lock, idle_grant, grant;
  logic       accepted, in_range;
  req_idx_t   win;
  logic [ADDR_W-1:0] win_address;

  // A simultaneous read and write counts as a write.
  assign pending = {m1_read | m1_write, m0_read | m0_write};
  assign is_wr   = {m1_write, m0_write};
  assign lock    = {m1_lock, m0_lock};

  anemo_rr_pick2 u_pick (
    .req   (pending),
    .last  (last_grant),
    .fixed (FIXED_PRIO),
    .grant (idle_grant)
  );

  assign accepted    = |grant;
  assign win         = grant[1];
  assign win_address = win ? m1_address : m0_address;
  assign in_range    = 32'(win_address) < 32'(DEPTH);

  // Grant and next state. An owner that is idle with lock released gives
  // the bus back in that same cycle, so the other side is not stalled for it.
  always_comb begin
    grant     = 2'b00;
    state_nxt = state;
    if (!reset) begin
      unique case (state)
        IDLE: grant = idle_grant;
        OWN0: grant = (pending[0] || lock[0]) ? {1'b0, pending[0]} : idle_grant;
        OWN1: grant = (pending[1] || lock[1]) ? {pending[1], 1'b0} : idle_grant;
        default: grant = 2'b00;
      endcase
      if (|grant) begin
        state_nxt = lock[grant[1]] ? (grant[1] ? OWN1 : OWN0) : IDLE;
      end else if ((state == OWN0 && !lock[0]) || (state == OWN1 && !lock[1])) begin
        state_nxt = IDLE;
      end
    end
  end

  assign m0_waitrequest = pending[0] & ~grant[0];
  assign m1_waitrequest = pending[1] & ~grant[1];
  assign ram_clken      = 1'b1;

  // RAM command for the accepted access; out-of-range accesses keep the
  // RAM deselected so a write cannot corrupt anything.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (accepted) begin
      ram_address    = win_address;
      ram_byteenable = win ? m1_byteenable : m0_byteenable;
      ram_writedata  = win ? m1_writedata : m0_writedata;
      ram_chipselect = in_range;
      ram_write      = is_wr[win] & in_range;
    end
  end

  // Ownership state, round-robin history and the read-return tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= RESET_LAST_GRANT;
      tag_valid  <= 1'b0;
      tag_owner  <= 1'b0;
      tag_oor    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tag_valid <= accepted & ~is_wr[win];
      tag_owner <= win;
      tag_oor   <= ~in_range;
      if (accepted) begin
        last_grant <= win;
      end
    end
  end

  // Return data goes only to the tagged owner and is zero otherwise.
  always_comb begin
    m0_readdatavalid = tag_valid & (tag_owner == 1'b0);
    m1_readdatavalid = tag_valid & (tag_owner == 1'b1);
    m0_readdata      = (m0_readdatavalid && !tag_oor) ? ram_readdata : '0;
    m1_readdata      = (m1_readdatavalid && !tag_oor) ? ram_readdata : '0;
  end

endmodule

// File: tb/tb_anemo_ram_arbiter.sv
// Directed bench for anemo_ram_arbiter with a behavioural one-cycle-latency
// RAM and a scoreboard of expected read returns.
module tb_anemo_ram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10240;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        lk;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mreq_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  logic reset;

  logic m0_read, m0_write, m0_lock, m0_waitrequest, m0_readdatavalid;
  logic [ADDR_W-1:0] m0_address;
  logic [3:0] m0_byteenable;
  logic [DATA_W-1:0] m0_writedata, m0_readdata;
  logic m1_read, m1_write, m1_lock, m1_waitrequest, m1_readdatavalid;
  logic [ADDR_W-1:0] m1_address;
  logic [3:0] m1_byteenable;
  logic [DATA_W-1:0] m1_writedata, m1_readdata;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0] ram_byteenable;
  logic ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_writedata;
  logic [DATA_W-1:0] ram_readdata = '0;

  logic [31:0] mem [DEPTH];
  sb_t sb [$];
  int errors = 0;
  int checks = 0;
  int cycle = 0;

  anemo_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_lock(m0_lock),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_lock(m1_lock),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata),
    .ram_clken(ram_clken)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled write, registered read one cycle later.
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  function automatic mreq_t idle();
    mreq_t r;
    r.rd = 1'b0; r.wr = 1'b0; r.lk = 1'b0; r.addr = '0; r.be = '0; r.wd = '0;
    return r;
  endfunction

  function automatic mreq_t rd(input int a, input logic lk);
    mreq_t r;
    r = idle();
    r.rd = 1'b1; r.lk = lk; r.addr = 14'(a); r.be = 4'hF;
    return r;
  endfunction

  function automatic mreq_t wr(input int a, input logic [3:0] be, input logic [31:0] d, input logic lk);
    mreq_t r;
    r = idle();
    r.wr = 1'b1; r.lk = lk; r.addr = 14'(a); r.be = be; r.wd = d;
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input mreq_t r0, input mreq_t r1);
    m0_read = r0.rd; m0_write = r0.wr; m0_lock = r0.lk;
    m0_address = r0.addr; m0_byteenable = r0.be; m0_writedata = r0.wd;
    m1_read = r1.rd; m1_write = r1.wr; m1_lock = r1.lk;
    m1_address = r1.addr; m1_byteenable = r1.be; m1_writedata = r1.wd;
  endtask

  // Checks waitrequests and read returns, then queues returns for reads
  // this cycle is expected to accept.
  task automatic checkOutput(input string tag, input mreq_t r0, input mreq_t r1,
                             input logic ew0, input logic ew1,
                             input logic [31:0] ed0, input logic [31:0] ed1);
    sb_t e;
    checkVal({tag, "_wait0"}, 32'(m0_waitrequest), 32'(ew0));
    checkVal({tag, "_wait1"}, 32'(m1_waitrequest), 32'(ew1));
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      checkVal({tag, "_rdv0"}, 32'(m0_readdatavalid), 32'(e.owner == 1'b0));
      checkVal({tag, "_rdv1"}, 32'(m1_readdatavalid), 32'(e.owner == 1'b1));
      checkVal({tag, "_rdata"}, e.owner ? m1_readdata : m0_readdata, e.data);
      checkVal({tag, "_rdata_other"}, e.owner ? m0_readdata : m1_readdata, 32'h0);
    end else begin
      checkVal({tag, "_rdv0_idle"}, 32'(m0_readdatavalid), 32'h0);
      checkVal({tag, "_rdv1_idle"}, 32'(m1_readdatavalid), 32'h0);
    end
    if (r0.rd && !r0.wr && !ew0) sb.push_back('{owner: 1'b0, data: ed0, due: cycle + 1});
    if (r1.rd && !r1.wr && !ew1) sb.push_back('{owner: 1'b1, data: ed1, due: cycle + 1});
  endtask

  task automatic doCycle(input string tag, input mreq_t r0, input mreq_t r1,
                         input logic ew0, input logic ew1,
                         input logic [31:0] ed0, input logic [31:0] ed1);
    @(posedge clk);
    #1;
    applyStimulus(r0, r1);
    @(negedge clk);
    cycle++;
    checkOutput(tag, r0, r1, ew0, ew1, ed0, ed1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
    reset = 1'b1;
    applyStimulus(idle(), idle());
    repeat (2) @(negedge clk);
    checkVal("rst_cs", 32'(ram_chipselect), 32'h0);
    checkVal("rst_we", 32'(ram_write), 32'h0);
    checkVal("rst_addr", 32'(ram_address), 32'h0);
    checkVal("rst_clken", 32'(ram_clken), 32'h1);
    checkVal("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'h0);
    reset = 1'b0;

    // Simultaneous reads after reset: m0 first, then m1.
    doCycle("both_rd_c1", rd(5, 0), rd(5, 0), 1'b0, 1'b1, pat(5), pat(5));
    doCycle("both_rd_c2", idle(), rd(5, 0), 1'b0, 1'b0, 32'h0, pat(5));
    doCycle("both_rd_c3", idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    // Conflicting writes alternate winners.
    for (int i = 0; i < 6; i++) begin
      doCycle($sformatf("wr_alt%0d", i), wr(20, 4'hF, 32'h1111_0000, 0),
              wr(21, 4'hF, 32'h2222_0000, 0), (i % 2) == 1, (i % 2) == 0, 32'h0, 32'h0);
      checkVal($sformatf("wr_alt%0d_addr", i), 32'(ram_address), (i % 2) == 0 ? 32'd20 : 32'd21);
      checkVal($sformatf("wr_alt%0d_we", i), 32'(ram_write), 32'h1);
    end

    // m1 locks the RAM for three writes; m0 waits then gets in on the 4th.
    doCycle("lk_pre", rd(5, 0), idle(), 1'b0, 1'b0, pat(5), 32'h0);
    for (int i = 1; i <= 3; i++)
      doCycle($sformatf("lk_c%0d", i), rd(5, 0), wr(100, 4'hF, 32'hDEAD_BEEF, 1),
              1'b1, 1'b0, pat(5), 32'h0);
    doCycle("lk_c4", rd(5, 0), idle(), 1'b0, 1'b0, pat(5), 32'h0);
    doCycle("lk_rd100", rd(100, 0), idle(), 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    doCycle("lk_drain", idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    // Out-of-range read: RAM deselected, zero data at normal latency.
    doCycle("oor_rd", rd(10240, 0), idle(), 1'b0, 1'b0, 32'h0, 32'h0);
    checkVal("oor_cs", 32'(ram_chipselect), 32'h0);
    doCycle("oor_ret", idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    // Byte-lane write only touches byte 1.
    doCycle("be_wr", wr(7, 4'b0010, 32'h0000_AB00, 0), idle(), 1'b0, 1'b0, 32'h0, 32'h0);
    checkVal("be_lanes", 32'(ram_byteenable), 32'h2);
    doCycle("be_rd", rd(7, 0), idle(), 1'b0, 1'b0, 32'hA500_AB07, 32'h0);
    doCycle("be_ret", idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back reads from alternating requesters; m0 won last.
    for (int i = 0; i < 4; i++)
      doCycle($sformatf("rd_alt%0d", i), rd(1, 0), rd(2, 0),
              (i % 2) == 0, (i % 2) == 1, pat(1), pat(2));
    doCycle("rd_alt_drain", idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset right after a read is accepted discards its return.
    doCycle("rst_rd", rd(5, 0), idle(), 1'b0, 1'b0, pat(5), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(idle(), idle());
    sb.delete();
    @(negedge clk);
    cycle++;
    checkVal("rst_mid_rdv0", 32'(m0_readdatavalid), 32'h0);
    checkVal("rst_mid_rdata0", m0_readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      doCycle($sformatf("post_rst%0d", i), idle(), idle(), 1'b0, 1'b0, 32'h0, 32'h0);

    checkVal("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
